// File: rtl/cpu_sequencer_pkg.sv
// Shared ISA, ALU-control and sequencer definitions for the 8-bit accumulator softcore.
package cpu_sequencer_pkg;

  localparam int unsigned BIT_COUNT      = 8;
  localparam int unsigned ALU_MODE_COUNT = 8;
  localparam int unsigned ALU_FLAG_COUNT = 2;
  localparam int unsigned PC_STEP        = 2;

  localparam int unsigned ALU_FLAG_EQ = 0;
  localparam int unsigned ALU_FLAG_GT = 1;

  typedef logic [ALU_MODE_COUNT-1:0] alu_mode_t;

  localparam alu_mode_t ALU_MODE_NONE     = 8'h00;
  localparam alu_mode_t ALU_MODE_ADD      = 8'h01;
  localparam alu_mode_t ALU_MODE_SHIFT    = 8'h02;
  localparam alu_mode_t ALU_MODE_NOT      = 8'h04;
  localparam alu_mode_t ALU_MODE_AND      = 8'h08;
  localparam alu_mode_t ALU_MODE_OR       = 8'h10;
  localparam alu_mode_t ALU_MODE_XOR      = 8'h20;
  localparam alu_mode_t ALU_MODE_BYPASS_A = 8'h40;
  localparam alu_mode_t ALU_MODE_BYPASS_B = 8'h80;

  localparam logic [1:0] ALU_B_SEL_REG    = 2'd0;
  localparam logic [1:0] ALU_B_SEL_IMM    = 2'd1;
  localparam logic [1:0] ALU_B_SEL_STEP   = 2'd2;
  localparam logic [1:0] ALU_B_SEL_TARGET = 2'd3;

  localparam logic [3:0] ISA_NOP  = 4'h0;
  localparam logic [3:0] ISA_ADD  = 4'h1;
  localparam logic [3:0] ISA_ADDI = 4'h2;
  localparam logic [3:0] ISA_SH   = 4'h3;
  localparam logic [3:0] ISA_SHI  = 4'h4;
  localparam logic [3:0] ISA_NOT  = 4'h5;
  localparam logic [3:0] ISA_AND  = 4'h6;
  localparam logic [3:0] ISA_OR   = 4'h7;
  localparam logic [3:0] ISA_XOR  = 4'h8;
  localparam logic [3:0] ISA_ST   = 4'h9;
  localparam logic [3:0] ISA_LDX  = 4'hA;
  localparam logic [3:0] ISA_BEQ  = 4'hB;
  localparam logic [3:0] ISA_BGT  = 4'hC;
  localparam logic [3:0] ISA_HALT = 4'hE;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH0,
    SEQ_FETCH1,
    SEQ_EXEC,
    SEQ_PCUPD,
    SEQ_HALT
  } seq_state_t;

  typedef struct packed {
    alu_mode_t  alu_mode;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       acc_we;
    logic       xreg_we;
    logic       is_branch;
    logic       branch_on_gt;
    logic       is_halt;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/cpu_sequencer_insn_decoder.sv
// Combinational decode of opcode/field into execute-cycle ALU controls and write enables.
module cpu_sequencer_insn_decoder
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] field,
  output dec_t       dec
);

  logic reg_form;

  always_comb begin
    dec      = '0;
    reg_form = 1'b0;
    case (opcode)
      ISA_NOP:  ;
      ISA_ADD:  begin dec.alu_mode = ALU_MODE_ADD;   dec.acc_we = 1'b1; reg_form = 1'b1; end
      ISA_ADDI: begin dec.alu_mode = ALU_MODE_ADD;   dec.acc_we = 1'b1; dec.alu_b_sel = ALU_B_SEL_IMM; end
      ISA_SH:   begin dec.alu_mode = ALU_MODE_SHIFT; dec.acc_we = 1'b1; reg_form = 1'b1; end
      ISA_SHI:  begin dec.alu_mode = ALU_MODE_SHIFT; dec.acc_we = 1'b1; dec.alu_b_sel = ALU_B_SEL_IMM; end
      ISA_NOT:  begin dec.alu_mode = ALU_MODE_NOT;   dec.acc_we = 1'b1; end
      ISA_AND:  begin dec.alu_mode = ALU_MODE_AND;   dec.acc_we = 1'b1; reg_form = 1'b1; end
      ISA_OR:   begin dec.alu_mode = ALU_MODE_OR;    dec.acc_we = 1'b1; reg_form = 1'b1; end
      ISA_XOR:  begin dec.alu_mode = ALU_MODE_XOR;   dec.acc_we = 1'b1; reg_form = 1'b1; end
      ISA_ST:   begin dec.alu_mode = ALU_MODE_BYPASS_A; dec.xreg_we = 1'b1; reg_form = 1'b1; end
      ISA_LDX:  begin dec.alu_mode = ALU_MODE_BYPASS_B; dec.acc_we  = 1'b1; reg_form = 1'b1; end
      ISA_BEQ:  begin dec.is_branch = 1'b1; reg_form = 1'b1; end
      ISA_BGT:  begin dec.is_branch = 1'b1; dec.branch_on_gt = 1'b1; reg_form = 1'b1; end
      ISA_HALT: dec.is_halt = 1'b1;
      default:  dec.illegal = 1'b1;
    endcase
    // x7 does not exist and field[3] is reserved in register forms
    if (reg_form && (field[3] || field[2:0] == 3'd7)) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute/PC-update sequencer; owns the IR and drives the shared ALU controls.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BIT_COUNT-1:0]      pc,
  output logic                      mem_req,
  output logic [BIT_COUNT-1:0]      mem_addr,
  input  logic                      mem_ready,
  input  logic [BIT_COUNT-1:0]      mem_rdata,
  output logic [ALU_MODE_COUNT-1:0] alu_mode,
  output logic                      alu_a_sel,
  output logic [1:0]                alu_b_sel,
  output logic [2:0]                b_reg_idx,
  output logic [3:0]                imm,
  output logic [BIT_COUNT-1:0]      target,
  input  logic [ALU_FLAG_COUNT-1:0] alu_flags,
  output logic                      acc_we,
  output logic                      xreg_we,
  output logic                      pc_we,
  output logic                      halted,
  output logic                      illegal_insn
);

  seq_state_t               state;
  logic [2*BIT_COUNT-1:0]   ir;
  logic                     addr_odd;
  dec_t                     dec;
  logic                     taken;

  cpu_sequencer_insn_decoder u_decoder (
    .opcode (ir[15:12]),
    .field  (ir[11:8]),
    .dec    (dec)
  );

  assign taken = dec.is_branch &
                 (dec.branch_on_gt ? alu_flags[ALU_FLAG_GT] : alu_flags[ALU_FLAG_EQ]);

  // pc changes on the same edge that enters FETCH0, so the address follows pc directly
  assign mem_addr  = mem_req ? {pc[BIT_COUNT-1:1], pc[0] | addr_odd} : '0;
  assign imm       = ir[11:8];
  assign b_reg_idx = ir[10:8];
  assign target    = ir[7:0];

  // Outputs are registered for the state being entered; the taken decision is latched into the PCUPD selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SEQ_IDLE;
      ir           <= '0;
      addr_odd     <= 1'b0;
      mem_req      <= 1'b0;
      alu_mode     <= ALU_MODE_NONE;
      alu_a_sel    <= 1'b0;
      alu_b_sel    <= ALU_B_SEL_REG;
      acc_we       <= 1'b0;
      xreg_we      <= 1'b0;
      pc_we        <= 1'b0;
      halted       <= 1'b0;
      illegal_insn <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          state    <= SEQ_FETCH0;
          mem_req  <= 1'b1;
          addr_odd <= 1'b0;
        end
        SEQ_FETCH0: begin
          if (mem_ready) begin
            ir[15:8] <= mem_rdata;
            addr_odd <= 1'b1;
            state    <= SEQ_FETCH1;
          end
        end
        SEQ_FETCH1: begin
          if (mem_ready) begin
            ir[7:0]   <= mem_rdata;
            mem_req   <= 1'b0;
            addr_odd  <= 1'b0;
            alu_mode  <= dec.alu_mode;
            alu_a_sel <= dec.alu_a_sel;
            alu_b_sel <= dec.alu_b_sel;
            acc_we    <= dec.acc_we;
            xreg_we   <= dec.xreg_we;
            state     <= SEQ_EXEC;
          end
        end
        SEQ_EXEC: begin
          acc_we  <= 1'b0;
          xreg_we <= 1'b0;
          if (dec.illegal || dec.is_halt) begin
            alu_mode  <= ALU_MODE_NONE;
            alu_a_sel <= 1'b0;
            alu_b_sel <= ALU_B_SEL_REG;
            halted    <= 1'b1;
            if (dec.illegal) illegal_insn <= 1'b1;
            state     <= SEQ_HALT;
          end else begin
            alu_mode  <= taken ? ALU_MODE_BYPASS_B : ALU_MODE_ADD;
            alu_a_sel <= 1'b1;
            alu_b_sel <= taken ? ALU_B_SEL_TARGET : ALU_B_SEL_STEP;
            pc_we     <= 1'b1;
            state     <= SEQ_PCUPD;
          end
        end
        SEQ_PCUPD: begin
          alu_mode  <= ALU_MODE_NONE;
          alu_a_sel <= 1'b0;
          alu_b_sel <= ALU_B_SEL_REG;
          pc_we     <= 1'b0;
          mem_req   <= 1'b1;
          addr_odd  <= 1'b0;
          state     <= SEQ_FETCH0;
        end
        SEQ_HALT: ;
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: fetch handshake, decode, branch PC update, halt and reset.
module tb_cpu_sequencer;

  localparam logic [7:0] M_ADD = 8'h01;
  localparam logic [7:0] M_BPA = 8'h40;
  localparam logic [7:0] M_BPB = 8'h80;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pc;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic [7:0] alu_mode;
  logic       alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [2:0] b_reg_idx;
  logic [3:0] imm;
  logic [7:0] target;
  logic [1:0] alu_flags;
  logic       acc_we;
  logic       xreg_we;
  logic       pc_we;
  logic       halted;
  logic       illegal_insn;

  int errors = 0;
  int checks = 0;

  logic [16:0] ctl;
  logic [22:0] dat;
  assign ctl = {mem_req, alu_mode, alu_a_sel, alu_b_sel, acc_we, xreg_we, pc_we, halted, illegal_insn};
  assign dat = {mem_addr, target, imm, b_reg_idx};

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .alu_mode     (alu_mode),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .b_reg_idx    (b_reg_idx),
    .imm          (imm),
    .target       (target),
    .alu_flags    (alu_flags),
    .acc_we       (acc_we),
    .xreg_we      (xreg_we),
    .pc_we        (pc_we),
    .halted       (halted),
    .illegal_insn (illegal_insn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH0, ends observed in EXEC
  task automatic fetch(input logic [7:0] b0, input logic [7:0] b1, input int waits);
    mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_req", 32'(mem_req), 32'h1);
      chk("wait_addr", 32'(mem_addr), 32'(pc));
    end
    mem_rdata = b0;
    mem_ready = 1'b1;
    tick();
    chk("f1_req", 32'(mem_req), 32'h1);
    chk("f1_addr", 32'(mem_addr), 32'(pc | 8'h01));
    mem_rdata = b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    chk("exec_req", 32'(mem_req), 32'h0);
  endtask

  initial begin
    rst = 1'b1; pc = 8'h00; mem_ready = 1'b0; mem_rdata = 8'h00; alu_flags = 2'b00;

    // reset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ctl", 32'(ctl), 32'h0);
    end
    chk("rst_dat", 32'(dat), 32'h0);
    rst = 1'b0;
    #3;
    chk("idle_req", 32'(mem_req), 32'h0);
    tick();
    chk("fetch0_req", 32'(mem_req), 32'h1);
    chk("fetch0_addr", 32'(mem_addr), 32'h00);

    // ADDI 3, zero wait
    pc = 8'h10;
    #1;
    chk("addr_follow", 32'(mem_addr), 32'h10);
    fetch(8'h23, 8'h00, 0);
    chk("addi_mode", 32'(alu_mode), 32'(M_ADD));
    chk("addi_bsel", 32'(alu_b_sel), 32'h1);
    chk("addi_asel", 32'(alu_a_sel), 32'h0);
    chk("addi_imm", 32'(imm), 32'h3);
    chk("addi_we", 32'({acc_we, xreg_we, pc_we}), 32'h4);
    tick();
    chk("addi_pc_we", 32'({acc_we, xreg_we, pc_we}), 32'h1);
    chk("addi_pc_mode", 32'(alu_mode), 32'(M_ADD));
    chk("addi_pc_sel", 32'({alu_a_sel, alu_b_sel}), 32'h6);
    tick();
    chk("addi_next_req", 32'(mem_req), 32'h1);
    chk("addi_next_ctl", 32'(ctl), 32'h10000);

    // same ADDI with 3 wait states
    fetch(8'h23, 8'h00, 3);
    chk("slow_exec_we", 32'(acc_we), 32'h1);
    tick();
    chk("slow_pcupd", 32'(pc_we), 32'h1);
    tick();
    chk("slow_next_req", 32'(mem_req), 32'h1);
    chk("slow_next_addr", 32'(mem_addr), 32'h10);

    // BEQ x2 taken
    pc = 8'h20;
    fetch(8'hB2, 8'h40, 0);
    chk("beq_exec_mode", 32'(alu_mode), 32'h0);
    chk("beq_exec_we", 32'({acc_we, xreg_we, pc_we}), 32'h0);
    chk("beq_idx", 32'(b_reg_idx), 32'h2);
    chk("beq_target", 32'(target), 32'h40);
    alu_flags = 2'b01;
    tick();
    alu_flags = 2'b00;
    chk("beq_t_mode", 32'(alu_mode), 32'(M_BPB));
    chk("beq_t_sel", 32'({alu_a_sel, alu_b_sel}), 32'h7);
    chk("beq_t_we", 32'({acc_we, xreg_we, pc_we}), 32'h1);
    pc = 8'h40;
    tick();
    chk("beq_t_next", 32'(mem_addr), 32'h40);

    // BEQ not taken (GT alone must not take it)
    fetch(8'hB2, 8'h60, 0);
    alu_flags = 2'b10;
    tick();
    alu_flags = 2'b00;
    chk("beq_nt_mode", 32'(alu_mode), 32'(M_ADD));
    chk("beq_nt_sel", 32'(alu_b_sel), 32'h2);
    pc = 8'h42;
    tick();

    // BGT taken
    fetch(8'hC1, 8'h08, 0);
    alu_flags = 2'b10;
    tick();
    alu_flags = 2'b00;
    chk("bgt_t_mode", 32'(alu_mode), 32'(M_BPB));
    chk("bgt_t_sel", 32'(alu_b_sel), 32'h3);
    pc = 8'h08;
    tick();

    // ST x3
    fetch(8'h93, 8'h00, 0);
    chk("st_mode", 32'(alu_mode), 32'(M_BPA));
    chk("st_we", 32'({acc_we, xreg_we, pc_we}), 32'h2);
    chk("st_idx", 32'(b_reg_idx), 32'h3);
    chk("st_sel", 32'({alu_a_sel, alu_b_sel}), 32'h0);
    tick();
    chk("st_pc_we", 32'({acc_we, xreg_we, pc_we}), 32'h1);
    pc = 8'h0A;
    tick();

    // NOP at 0xFE, PC wraps through the ALU
    pc = 8'hFE;
    fetch(8'h00, 8'h00, 0);
    chk("nop_exec", 32'(ctl), 32'h0);
    tick();
    chk("nop_pc_mode", 32'(alu_mode), 32'(M_ADD));
    chk("nop_pc_sel", 32'({alu_a_sel, alu_b_sel}), 32'h6);
    chk("nop_pc_we", 32'(pc_we), 32'h1);
    pc = 8'h00;
    tick();
    chk("wrap_addr", 32'(mem_addr), 32'h00);

    // reset during FETCH1 drops the request immediately
    mem_rdata = 8'h23; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("f1_before_rst", 32'(mem_addr), 32'h01);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'h0);
    chk("rst_async_dat", 32'(dat), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_refetch", 32'({mem_req, mem_addr}), 32'h100);

    // illegal opcode D
    fetch(8'hD0, 8'h00, 0);
    chk("ill_d_exec", 32'(ctl), 32'h0);
    tick();
    chk("ill_d_halt", 32'({halted, illegal_insn}), 32'h3);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ill_d_stay", 32'(ctl), 32'h3);
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("ill_d_clear", 32'(ctl), 32'h0);
    rst = 1'b0;
    tick();

    // ADD with field[3]=1 is illegal
    fetch(8'h18, 8'h00, 0);
    chk("ill_18_exec", 32'(ctl), 32'h0);
    tick();
    chk("ill_18_halt", 32'(ctl), 32'h3);
    tick();
    chk("ill_18_stay", 32'(ctl), 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // HALT opcode halts without flagging illegal
    fetch(8'hE0, 8'h00, 0);
    tick();
    chk("halt_op", 32'(ctl), 32'h2);
    tick();
    chk("halt_stay", 32'(ctl), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
